div5_seq_chunked: RTL and testbench

Sequential constant divider by 5 for a W-bit unsigned dividend.
- Walks the dividend MSB-first, 3 bits per cycle, through a combinational per-chunk digit cell.
- Produces the full quotient and the 3-bit remainder behind a valid/ready handshake.
- Sits directly upstream of the result consumer. It is the iterative wrapper that drives the per-chunk quotient-digit logic of the 64-bit divide-by-5 datapath.

---
 rtl/div5_seq_chunked_pkg.sv | 10 +
 rtl/div5_seq_chunked_digit3.sv | 15 +
 rtl/div5_seq_chunked.sv | 86 ++++++++
 tb/tb_div5_seq_chunked.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/div5_seq_chunked_pkg.sv
// div_const_pkg: shared state encoding, constants and chunk-count helper for the divide-by-5 datapath
package div_const_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int DIVISOR = 5;
  localparam int CHUNK = 3;
  localparam int REM_W = 3;
  function automatic int nchunk(input int w);
    return (w + CHUNK - 1) / CHUNK;
  endfunction
endpackage

// File: rtl/div5_seq_chunked_digit3.sv
// div5_digit3: one radix-8 step of divide-by-5, {rem_in,chunk} -> quotient digit and new remainder
module div5_digit3
  import div_const_pkg::*;
(
  input  logic [REM_W-1:0] rem_in,
  input  logic [2:0]       chunk,
  output logic [2:0]       digit,
  output logic [REM_W-1:0] rem_out
);
  logic [5:0] v;
  assign v = {rem_in, chunk};
  assign digit = 3'(v / 6'(DIVISOR));
  assign rem_out = REM_W'(v % 6'(DIVISOR));
  always_comb assert (rem_in < REM_W'(DIVISOR));
endmodule

// File: rtl/div5_seq_chunked.sv
// div5_seq_chunked: iterative MSB-first divide-by-5, 3 dividend bits per cycle, valid/ready on both sides
module div5_seq_chunked #(
  parameter int W = 64,
  parameter int CHUNK = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_dividend,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_quot,
  output logic [2:0]   out_rem,
  output logic         busy
);
  import div_const_pkg::*;
  localparam int NCHUNK = nchunk(W);
  localparam int OP_W = 3 * NCHUNK;
  localparam int CW = $clog2(NCHUNK + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0] op_q, op_d, acc_q, acc_d;
  logic [2:0] rem_q, rem_d, orem_q, orem_d, digit, rem_nx;
  logic [W-1:0] quot_q, quot_d;
  div5_digit3 u_digit (
    .rem_in (rem_q),
    .chunk  (op_q[OP_W-1 -: 3]),
    .digit  (digit),
    .rem_out(rem_nx)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    op_d = op_q;
    acc_d = acc_q;
    rem_d = rem_q;
    quot_d = quot_q;
    orem_d = orem_q;
    if (state_q == IDLE && in_valid) begin
      op_d = OP_W'(in_dividend);
      acc_d = '0;
      rem_d = '0;
      cnt_d = CW'(NCHUNK - 1);
      state_d = RUN;
    end else if (state_q == RUN) begin
      op_d = op_q << 3;
      acc_d = (acc_q << 3) | OP_W'(digit);
      rem_d = rem_nx;
      cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
      state_d = (cnt_q == '0) ? DONE : RUN;
      quot_d = (cnt_q == '0) ? acc_d[W-1:0] : quot_q;
      orem_d = (cnt_q == '0) ? rem_nx : orem_q;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_q <= '0;
      acc_q <= '0;
      rem_q <= '0;
      quot_q <= '0;
      orem_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      acc_q <= acc_d;
      rem_q <= rem_d;
      quot_q <= quot_d;
      orem_q <= orem_d;
    end
  end
  always_ff @(posedge clk) assert (CHUNK == 3);
  if (OP_W > W) begin : g_hi
    always_ff @(posedge clk) if (rst_n && state_q == DONE) assert (acc_q[OP_W-1:W] == '0);
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign out_quot = quot_q;
  assign out_rem = orem_q;
endmodule

// File: tb/tb_div5_seq_chunked.sv
// tb_div5_seq_chunked: scoreboard bench for div5_seq_chunked against plain 64-bit arithmetic
module tb_div5_seq_chunked;
  typedef struct {
    logic [63:0] d;
    logic [63:0] q;
    logic [2:0]  r;
  } exp_t;
  logic clk = 0;
  logic rst_n = 0;
  logic in_valid = 0;
  logic in_ready;
  logic [63:0] in_dividend = '0;
  logic out_valid;
  logic out_ready = 0;
  logic [63:0] out_quot;
  logic [2:0] out_rem;
  logic busy;
  int errs = 0;
  int checks = 0;
  int cyc = 0;
  bit drv_done = 0;
  exp_t sb[$];
  div5_seq_chunked #(.W(64), .CHUNK(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .out_valid(out_valid), .out_ready(out_ready),
    .out_quot(out_quot), .out_rem(out_rem), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", n, got, exp, cyc);
    end
  endfunction
  always @(negedge clk) if (rst_n && in_valid && in_ready)
    sb.push_back('{in_dividend, in_dividend / 64'd5, 3'(in_dividend % 64'd5)});
  always @(negedge clk) if (rst_n && out_valid && out_ready) begin
    if (sb.size() == 0) begin
      checks++;
      errs++;
      $display("FAIL unexpected_result got q=%0h r=%0d exp none", out_quot, out_rem);
    end else begin
      exp_t e;
      e = sb.pop_front();
      chk("quot", out_quot, e.q);
      chk("rem", 64'(out_rem), 64'(e.r));
    end
  end
  function automatic logic [63:0] rnd64();
    int k;
    k = $urandom_range(0, 7);
    return (k == 0) ? 64'd0 : (k == 1) ? '1 : ({$urandom, $urandom} >> $urandom_range(0, 63));
  endfunction
  task automatic do_div(input logic [63:0] d, input int stall);
    int a, b;
    bit ok;
    @(posedge clk); #1;
    in_valid = 1;
    in_dividend = d;
    out_ready = (stall == 0);
    a = -1;
    for (int i = 0; i < 50 && a < 0; i++) begin
      @(negedge clk);
      if (in_ready) a = cyc;
    end
    @(posedge clk); #1;
    in_valid = 0;
    in_dividend = {$urandom, $urandom};
    if (a < 0) begin
      chk("accept_timeout", 0, 1);
      return;
    end
    ok = 1;
    b = -1;
    for (int i = 0; i < 100 && b < 0; i++) begin
      @(negedge clk);
      if (out_valid) b = cyc;
      else if (in_ready) ok = 0;
    end
    chk("in_ready_low_run", 64'(ok), 1);
    chk("latency", 64'(b - a), 23);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", 64'(out_valid), 1);
      chk("stall_quot", out_quot, d / 64'd5);
      chk("stall_rem", 64'(out_rem), d % 64'd5);
      chk("stall_in_ready", 64'(in_ready), 0);
    end
    if (stall > 0) begin
      @(posedge clk); #1;
      out_ready = 1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("in_ready_after", 64'(in_ready), 1);
  endtask
  initial begin
    int a;
    bit quiet;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_quot", out_quot, 0);
    chk("rst_rem", 64'(out_rem), 0);
    chk("rst_busy", 64'(busy), 0);
    @(posedge clk); #1;
    rst_n = 1;
    do_div(64'd100, 0);
    do_div(64'd7, 0);
    do_div(64'd0, 0);
    do_div('1, 0);
    do_div(64'd123456789, 10);
    @(posedge clk); #1;
    in_valid = 1;
    in_dividend = 64'd555;
    a = -1;
    for (int i = 0; i < 50 && a < 0; i++) begin
      @(negedge clk);
      if (in_ready) a = cyc;
    end
    @(posedge clk); #1;
    in_valid = 0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("run_busy", 64'(busy), 1);
    @(posedge clk); #1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    sb.delete();
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 1);
    chk("midrst_busy", 64'(busy), 0);
    chk("midrst_valid", 64'(out_valid), 0);
    chk("midrst_quot", out_quot, 0);
    chk("midrst_rem", 64'(out_rem), 0);
    quiet = 1;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) quiet = 0;
    end
    chk("midrst_no_result", 64'(quiet), 1);
    do_div(64'd1000, 0);
    fork
      begin
        for (int i = 0; i < 1200; i++) begin
          logic [63:0] d;
          bit got;
          d = rnd64();
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          in_valid = 1;
          in_dividend = d;
          got = 0;
          for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            got = in_ready;
          end
          if (!got) chk("rand_accept_timeout", 0, 1);
          @(posedge clk); #1;
          in_valid = 0;
          in_dividend = {$urandom, $urandom};
        end
        drv_done = 1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk); #1;
          out_ready = $urandom_range(0, 2) != 0;
        end
      end
    join
    out_ready = 1;
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    repeat (2) @(negedge clk);
    chk("drain_empty", 64'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
